// File: rtl/alu_pipeline_pkg.sv
// alu_pipeline_pkg: shared opcode, funct and mult/div FSM encodings for the EX-stage ALU
package alu_pipeline_pkg;
    localparam logic [1:0] ALU_OP_ADD   = 2'b00;
    localparam logic [1:0] ALU_OP_SUB   = 2'b01;
    localparam logic [1:0] ALU_OP_FUNCT = 2'b10;
    localparam logic [1:0] ALU_OP_MEM   = 2'b11;

    localparam logic [5:0] FUNCT_ADD   = 6'b100000;
    localparam logic [5:0] FUNCT_SUB   = 6'b100010;
    localparam logic [5:0] FUNCT_AND   = 6'b100100;
    localparam logic [5:0] FUNCT_OR    = 6'b100101;
    localparam logic [5:0] FUNCT_XOR   = 6'b100110;
    localparam logic [5:0] FUNCT_NOR   = 6'b100111;
    localparam logic [5:0] FUNCT_SLT   = 6'b101010;
    localparam logic [5:0] FUNCT_SLTU  = 6'b101011;
    localparam logic [5:0] FUNCT_MFHI  = 6'b010000;
    localparam logic [5:0] FUNCT_MFLO  = 6'b010010;
    localparam logic [5:0] FUNCT_MULT  = 6'b011000;
    localparam logic [5:0] FUNCT_MULTU = 6'b011001;
    localparam logic [5:0] FUNCT_DIV   = 6'b011010;
    localparam logic [5:0] FUNCT_DIVU  = 6'b011011;

    typedef enum logic [1:0] {ST_IDLE, ST_MUL, ST_DIV, ST_FIN} md_state_e;
endpackage

// File: rtl/alu_muldiv_iter.sv
// alu_muldiv_iter: iterative shift-add multiplier / restoring divider on operand magnitudes
module alu_muldiv_iter
    import alu_pipeline_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             is_div,
    input  logic             sgn,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             busy,
    output logic             fin,
    output logic             dz,
    output logic [WIDTH-1:0] hi_res,
    output logic [WIDTH-1:0] lo_res
);
    localparam int CW = $clog2(WIDTH + 1);

    md_state_e state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [WIDTH-1:0] rem_q, rem_d, quo_q, quo_d, dvs_q, dvs_d, a_q, a_d, abs_a, abs_b;
    logic neg_q, neg_d, rneg_q, rneg_d, dz_q, dz_d, div_q, div_d;
    logic [WIDTH:0] sum, shl, diff;
    logic [2*WIDTH-1:0] prod;

    always_comb begin
        abs_a = (sgn && a[WIDTH-1]) ? -a : a;
        abs_b = (sgn && b[WIDTH-1]) ? -b : b;
        sum   = {1'b0, rem_q} + (quo_q[0] ? {1'b0, dvs_q} : '0);
        shl   = {rem_q, quo_q[WIDTH-1]};
        diff  = shl - {1'b0, dvs_q};
        prod  = neg_q ? -{rem_q, quo_q} : {rem_q, quo_q};
        state_d = state_q;
        cnt_d   = cnt_q;
        rem_d   = rem_q;
        quo_d   = quo_q;
        dvs_d   = dvs_q;
        a_d     = a_q;
        neg_d   = neg_q;
        rneg_d  = rneg_q;
        dz_d    = dz_q;
        div_d   = div_q;
        case (state_q)
            ST_IDLE: if (start) begin
                state_d = is_div ? ST_DIV : ST_MUL;
                cnt_d   = CW'(WIDTH);
                rem_d   = '0;
                quo_d   = abs_a;
                dvs_d   = abs_b;
                a_d     = a;
                neg_d   = sgn && (a[WIDTH-1] ^ b[WIDTH-1]);
                rneg_d  = sgn && a[WIDTH-1];
                dz_d    = is_div && (b == '0);
                div_d   = is_div;
            end
            ST_MUL: begin
                {rem_d, quo_d} = {sum, quo_q[WIDTH-1:1]};
                cnt_d   = cnt_q - 1'b1;
                state_d = (cnt_q == CW'(1)) ? ST_FIN : ST_MUL;
            end
            ST_DIV: begin
                rem_d   = diff[WIDTH] ? shl[WIDTH-1:0] : diff[WIDTH-1:0];
                quo_d   = {quo_q[WIDTH-2:0], ~diff[WIDTH]};
                cnt_d   = cnt_q - 1'b1;
                state_d = (cnt_q == CW'(1)) ? ST_DIV : ST_DIV;
                state_d = (cnt_q == CW'(1)) ? ST_FIN : state_d;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_IDLE;
            cnt_q   <= '0;
            rem_q   <= '0;
            quo_q   <= '0;
            dvs_q   <= '0;
            a_q     <= '0;
            neg_q   <= 1'b0;
            rneg_q  <= 1'b0;
            dz_q    <= 1'b0;
            div_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            rem_q   <= rem_d;
            quo_q   <= quo_d;
            dvs_q   <= dvs_d;
            a_q     <= a_d;
            neg_q   <= neg_d;
            rneg_q  <= rneg_d;
            dz_q    <= dz_d;
            div_q   <= div_d;
        end
    end

    // divide-by-zero overrides whatever the divider loop left behind
    assign busy   = state_q != ST_IDLE;
    assign fin    = state_q == ST_FIN;
    assign dz     = dz_q;
    assign lo_res = dz_q ? '1  : div_q ? (neg_q ? -quo_q : quo_q)  : prod[WIDTH-1:0];
    assign hi_res = dz_q ? a_q : div_q ? (rneg_q ? -rem_q : rem_q) : prod[2*WIDTH-1:WIDTH];
endmodule

// File: rtl/alu_muldiv_pipeline.sv
// alu_muldiv_pipeline: EX-stage ALU with registered results, flags and a HI/LO mult/div unit
module alu_muldiv_pipeline
    import alu_pipeline_pkg::*;
#(
    parameter int WIDTH   = 32,
    parameter int FUNCT_W = 6
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               start,
    input  logic [1:0]         aluOP,
    input  logic [FUNCT_W-1:0] sel,
    input  logic [WIDTH-1:0]   a,
    input  logic [WIDTH-1:0]   b,
    output logic [WIDTH-1:0]   ans,
    output logic               zero,
    output logic               overflow,
    output logic               div_zero,
    output logic               busy,
    output logic               done,
    output logic [WIDTH-1:0]   hi,
    output logic [WIDTH-1:0]   lo
);
    logic [WIDTH-1:0] ans_q, ans_d, hi_q, hi_d, lo_q, lo_d;
    logic [WIDTH-1:0] add_r, sub_r, f_res, s_res, md_hi, md_lo;
    logic zero_q, zero_d, ov_q, ov_d, dz_q, dz_d, done_q, done_d;
    logic is_f, f_mul, f_div, f_sgn, accept, md_fin, md_dz;
    logic add_ov, sub_ov, f_ov, s_ov, slt, sltu;

    function automatic logic hit(input logic [FUNCT_W-1:0] s, input logic [5:0] c);
        return s == FUNCT_W'(c);
    endfunction

    alu_muldiv_iter #(.WIDTH(WIDTH)) u_iter (
        .clk    (clk),
        .rst    (rst),
        .start  (accept && (f_mul || f_div)),
        .is_div (f_div),
        .sgn    (f_sgn),
        .a      (a),
        .b      (b),
        .busy   (busy),
        .fin    (md_fin),
        .dz     (md_dz),
        .hi_res (md_hi),
        .lo_res (md_lo)
    );

    always_comb begin
        is_f   = aluOP == ALU_OP_FUNCT;
        f_mul  = is_f && (hit(sel, FUNCT_MULT) || hit(sel, FUNCT_MULTU));
        f_div  = is_f && (hit(sel, FUNCT_DIV) || hit(sel, FUNCT_DIVU));
        f_sgn  = hit(sel, FUNCT_MULT) || hit(sel, FUNCT_DIV);
        accept = start && !busy;
        add_r  = a + b;
        sub_r  = a - b;
        add_ov = (a[WIDTH-1] == b[WIDTH-1]) && (add_r[WIDTH-1] != a[WIDTH-1]);
        sub_ov = (a[WIDTH-1] != b[WIDTH-1]) && (sub_r[WIDTH-1] != a[WIDTH-1]);
        slt    = $signed(a) < $signed(b);
        sltu   = a < b;
        f_res  = hit(sel, FUNCT_ADD)  ? add_r :
                 hit(sel, FUNCT_SUB)  ? sub_r :
                 hit(sel, FUNCT_AND)  ? a & b :
                 hit(sel, FUNCT_OR)   ? a | b :
                 hit(sel, FUNCT_XOR)  ? a ^ b :
                 hit(sel, FUNCT_NOR)  ? ~(a | b) :
                 hit(sel, FUNCT_SLT)  ? {{(WIDTH-1){1'b0}}, slt} :
                 hit(sel, FUNCT_SLTU) ? {{(WIDTH-1){1'b0}}, sltu} :
                 hit(sel, FUNCT_MFHI) ? hi_q :
                 hit(sel, FUNCT_MFLO) ? lo_q : '0;
        f_ov   = hit(sel, FUNCT_ADD) ? add_ov : hit(sel, FUNCT_SUB) ? sub_ov : 1'b0;
        s_res  = (aluOP == ALU_OP_SUB) ? sub_r  : is_f ? f_res : add_r;
        s_ov   = (aluOP == ALU_OP_SUB) ? sub_ov : is_f ? f_ov  : add_ov;
        ans_d  = ans_q;
        zero_d = zero_q;
        ov_d   = ov_q;
        dz_d   = dz_q;
        hi_d   = hi_q;
        lo_d   = lo_q;
        done_d = 1'b0;
        // engine completion and a single-cycle accept are mutually exclusive: fin implies busy
        if (md_fin) begin
            ans_d  = md_lo;
            hi_d   = md_hi;
            lo_d   = md_lo;
            zero_d = 1'b0;
            ov_d   = 1'b0;
            dz_d   = md_dz;
            done_d = 1'b1;
        end else if (accept && !(f_mul || f_div)) begin
            ans_d  = s_res;
            zero_d = (aluOP == ALU_OP_SUB) && (sub_r == '0);
            ov_d   = s_ov;
            dz_d   = 1'b0;
            done_d = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            ans_q  <= '0;
            hi_q   <= '0;
            lo_q   <= '0;
            zero_q <= 1'b0;
            ov_q   <= 1'b0;
            dz_q   <= 1'b0;
            done_q <= 1'b0;
        end else begin
            ans_q  <= ans_d;
            hi_q   <= hi_d;
            lo_q   <= lo_d;
            zero_q <= zero_d;
            ov_q   <= ov_d;
            dz_q   <= dz_d;
            done_q <= done_d;
        end
    end

    assign ans      = ans_q;
    assign zero     = zero_q;
    assign overflow = ov_q;
    assign div_zero = dz_q;
    assign done     = done_q;
    assign hi       = hi_q;
    assign lo       = lo_q;
endmodule

// File: doc/alu_muldiv_pipeline.md
Name: alu_muldiv_pipeline

Overview:
Parametrised successor to the pipeline ALU for the EX stage. Ports the same aluOP/funct decode to WIDTH bits and adds slt/sltu/nor and signed-overflow reporting. Adds an iterative multiply/divide engine with HI/LO registers and a start/busy/done handshake, so the hazard unit can stall EX while a mult/div runs. All results are registered.

Parameters:
WIDTH, 32, datapath width in bits (even, >= 8)
FUNCT_W, 6, width of the funct select field

Ports:
clk  in  1  clock, rising edge
rst  in  1  synchronous reset, active-high
start  in  1  operation request; sampled only when busy=0
aluOP  in  2  00 add, 01 sub+zero, 10 funct decode, 11 add (lw/sw)
sel  in  FUNCT_W  funct field, used when aluOP=10
a  in  WIDTH  operand A (rs)
b  in  WIDTH  operand B (rt/imm)
ans  out  WIDTH  registered result
zero  out  1  registered; 1 only for aluOP=01 with a-b==0
overflow  out  1  registered signed overflow for add/sub; not a trap
div_zero  out  1  registered; 1 on the done cycle of div/divu with b==0
busy  out  1  mult/div in progress; start is ignored
done  out  1  one-cycle pulse, ans/flags valid
hi  out  WIDTH  HI register
lo  out  WIDTH  LO register

Behaviour:
- Reset: ans, zero, overflow, div_zero, busy, done, hi and lo are all 0; FSM goes to IDLE. Reset mid-operation aborts it, and no done pulse is produced.
- Funct codes (aluOP=10):
  - 100000 add, 100010 sub, 100100 and, 100101 or, 100110 xor, 100111 nor
  - 101010 slt (signed), 101011 sltu
  - 010000 mfhi, 010010 mflo
  - 011000 mult, 011001 multu, 011010 div, 011011 divu
  - any other code gives ans=0 and a normal done pulse.
- Single-cycle ops: start sampled at edge N. ans and flags are written at edge N, so done=1 during cycle N+1. busy stays 0, so back-to-back starts every cycle are legal.
- Add/sub are computed at WIDTH+1 bits and ans is truncated to WIDTH. overflow = operand signs equal (add) or different (sub) and result sign differs. overflow=0 for all other ops.
- slt/sltu: ans = {0..0, less}.
- FSM states: IDLE, MUL, DIV, FIN.
  - IDLE + start + mult/multu: load |a| and |b| (magnitudes only if signed), cnt=WIDTH, go to MUL.
  - IDLE + start + div/divu: same loading, go to DIV.
  - MUL: one shift-add step per cycle. DIV: one restoring shift-subtract step per cycle. cnt decrements; at cnt==1 go to FIN.
  - FIN: apply sign correction, write hi/lo and ans=lo, set done, go to IDLE.
- Multi-cycle latency: start at edge N; busy=1 in cycles N+1 .. N+WIDTH+1; done=1 and busy=0 in cycle N+WIDTH+2. A new start is accepted in the done cycle.
- mult/multu result: {hi,lo} = 2*WIDTH-bit product. Signed product is negated when sign(a)!=sign(b).
- div/divu result: lo=quotient, hi=remainder. Signed quotient truncates toward zero; remainder takes the sign of the dividend.
- div/divu with b==0: lo=all ones, hi=a, div_zero=1.
- Signed MIN / -1: lo=MIN, hi=0, no flag.
- start while busy: ignored entirely. Operands, hi and lo are unaffected and no extra done pulse occurs.
- mfhi/mflo read the committed hi/lo values. hi/lo change only in FIN or on reset.
- zero, overflow and div_zero hold their values until the next accepted op.

Decomposition:
- Package alu_pipeline_pkg holds:
  - ALU_OP_* localparams (2-bit)
  - FUNCT_* localparams (6-bit)
  - FSM state encoding (IDLE/MUL/DIV/FIN)
- Sub-module alu_muldiv_iter (iterative mult/div engine) contains:
  - operand, accumulator and count registers
  - start/done handshake with the top level
- Top level keeps the combinational decode, the result/flag registers and the hi/lo commit.

Test Plan:
1. aluOP=01, a=5, b=5 -> next cycle ans=0, zero=1, done=1. Then a=7, b=5 -> ans=2, zero=0.
2. aluOP=10, sel=101010, a=0xFFFFFFFF, b=1 -> ans=1. sel=101011 same operands -> ans=0. sel=100000, a=0x7FFFFFFF, b=1 -> ans=0x80000000, overflow=1.
3. mult, a=0xFFFFFFFD (-3), b=7, start at edge 0 -> busy cycles 1..33, done cycle 34: lo=0xFFFFFFEB, hi=0xFFFFFFFF, ans=lo. Then mfhi -> ans=0xFFFFFFFF.
4. div, a=-7, b=2 -> lo=0xFFFFFFFD, hi=0xFFFFFFFF. divu, a=9, b=0 -> lo=0xFFFFFFFF, hi=9, div_zero=1.
5. multu 3*4 started, then start pulsed with add during busy -> single done at cycle 34, lo=12, hi=0, no extra done.
6. mult started, rst=1 at cycle 10 -> next cycle busy=0, done=0, hi=lo=ans=0. A following add 2+3 -> ans=5 one cycle later.
